token_divider: RTL and testbench

- Reverse-direction counterpart of the token doubler: consumes a single-bit token stream and produces one output token per RATIO input tokens.
- Owed output tokens are queued in a saturating credit counter and drained over a valid/ready handshake, so a slow consumer does not lose tokens until the counter fills.
- Sits downstream of token-multiplying stages and recovers the original token count. RATIO=2 exactly undoes the doubler.

---
 rtl/token_divider.sv | 85 ++++++++
 tb/tb_token_divider.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/token_divider.sv
// token_divider: emits one output token per RATIO input tokens. Owed tokens are
// queued in a saturating counter and drained over a valid/ready handshake.
module token_divider #(
    parameter int RATIO = 2,
    parameter int CNT_W = 4,
    localparam int RW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a,
    input  logic          flush,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [RW-1:0] residue,
    output logic          overflow
);

    localparam logic [RW-1:0]    PHASE_LAST = RW'(RATIO - 1);
    localparam logic [RW-1:0]    PHASE_ONE  = RW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [RW-1:0]    phase_r;
    logic [RW-1:0]    phase_base_s;
    logic [RW-1:0]    phase_next_s;
    logic [CNT_W-1:0] pending_r;
    logic [CNT_W-1:0] pending_next_s;
    logic             overflow_r;
    logic             overflow_next_s;
    logic             inc_s;
    logic             dec_s;

    // Group counting: flush discards the partial group before a same-cycle token is counted.
    always_comb begin
        phase_base_s = flush ? {RW{1'b0}} : phase_r;
        phase_next_s = phase_base_s;
        inc_s        = 1'b0;
        if (a) begin
            if (phase_base_s == PHASE_LAST) begin
                phase_next_s = {RW{1'b0}};
                inc_s        = 1'b1;
            end else begin
                phase_next_s = phase_base_s + PHASE_ONE;
            end
        end else begin
            phase_next_s = phase_base_s;
        end
    end

    // Owed-token counter: saturates when full, and a simultaneous inc/dec cancels out.
    always_comb begin
        dec_s           = b_valid & b_ready;
        pending_next_s  = pending_r;
        overflow_next_s = overflow_r;
        if (inc_s && !dec_s) begin
            if (pending_r == CNT_MAX) begin
                overflow_next_s = 1'b1;
            end else begin
                pending_next_s = pending_r + CNT_ONE;
            end
        end else if (dec_s && !inc_s) begin
            pending_next_s = pending_r - CNT_ONE;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // State registers; reset clears queued and partial tokens immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r    <= {RW{1'b0}};
            pending_r  <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            phase_r    <= phase_next_s;
            pending_r  <= pending_next_s;
            overflow_r <= overflow_next_s;
        end
    end

    assign b_valid  = (pending_r != {CNT_W{1'b0}});
    assign residue  = phase_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_token_divider.sv
// Bench for token_divider: RATIO=2 and RATIO=4 instances checked against an
// arithmetic token-accounting model.
module tb_token_divider;

    localparam int MAXP = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       a2 = 1'b0, flush2 = 1'b0, ready2 = 1'b0, valid2, ovf2;
    logic [0:0] res2;
    logic       a4 = 1'b0, flush4 = 1'b0, ready4 = 1'b0, valid4, ovf4;
    logic [1:0] res4;

    int vectors = 0;
    int errors  = 0;
    int m_ph[2];
    int m_owed[2];
    bit m_ovf[2];
    int xfer[2];

    token_divider #(.RATIO(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .flush(flush2), .b_valid(valid2),
        .b_ready(ready2), .residue(res2), .overflow(ovf2)
    );

    token_divider #(.RATIO(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .flush(flush4), .b_valid(valid4),
        .b_ready(ready4), .residue(res4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_owed[k] = 0; m_ovf[k] = 1'b0; xfer[k] = 0;
        end
    endtask

    // Token accounting: tokens since the last group boundary, and owed outputs.
    task automatic model_update(input int k, input int r, input logic a, input logic fl, input logic rd);
        int c;
        bit inc;
        bit dec;
        dec = (m_owed[k] > 0) && rd;
        c   = fl ? 0 : m_ph[k];
        inc = 1'b0;
        if (a) begin
            c++;
            if (c == r) begin c = 0; inc = 1'b1; end
        end
        m_ph[k] = c;
        if (inc && !dec) begin
            if (m_owed[k] == MAXP) m_ovf[k] = 1'b1;
            else m_owed[k]++;
        end else if (dec && !inc) begin
            m_owed[k]--;
        end
    endtask

    task automatic tick();
        if (valid2 && ready2) xfer[0]++;
        if (valid4 && ready4) xfer[1]++;
        model_update(0, 2, a2, flush2, ready2);
        model_update(1, 4, a4, flush4, ready4);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        a2 = 1'b0; flush2 = 1'b0; ready2 = 1'b0;
        a4 = 1'b0; flush4 = 1'b0; ready4 = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear_model();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid2); end
        vectors++; if (res2 !== 1'b0)   begin errors++; $display("FAIL reset_residue got %b exp 0", res2); end
        vectors++; if (ovf2 !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b exp 0", ovf2); end
        do_reset();
        a2 = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        a2 = 1'b0;
        vectors++; if (valid2 !== 1'b1) begin errors++; $display("FAIL prefill_valid got %b exp 1", valid2); end
        vectors++; if (res2 !== 1'b1)   begin errors++; $display("FAIL prefill_residue got %b exp 1", res2); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (valid2 !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", valid2); end
        vectors++; if (res2 !== 1'b0)   begin errors++; $display("FAIL async_residue got %b exp 0", res2); end
        vectors++; if (ovf2 !== 1'b0)   begin errors++; $display("FAIL async_overflow got %b exp 0", ovf2); end
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        a2 = 1'b1;
        tick();
        vectors++; if (valid2 !== 1'b0) begin errors++; $display("FAIL post_rst_tok1 got %b exp 0", valid2); end
        tick();
        a2 = 1'b0;
        vectors++; if (valid2 !== 1'b1) begin errors++; $display("FAIL post_rst_tok2 got %b exp 1", valid2); end
    endtask

    task automatic test_ratio2();
        int sent = 0;
        do_reset();
        ready2 = 1'b1;
        for (int i = 0; i < 200 && sent < 10; i++) begin
            a2 = ($urandom_range(0, 1) == 0);
            if (a2) sent++;
            tick();
            vectors++; if (valid2 !== (m_owed[0] > 0)) begin errors++; $display("FAIL r2_valid t=%0t got %b exp %b", $time, valid2, m_owed[0] > 0); end
            vectors++; if (res2 !== 1'(m_ph[0])) begin errors++; $display("FAIL r2_residue t=%0t got %0d exp %0d", $time, res2, m_ph[0]); end
        end
        a2 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (xfer[0] !== 5) begin errors++; $display("FAIL r2_transfers got %0d exp 5 (sent %0d)", xfer[0], sent); end
    endtask

    task automatic test_round_trip();
        int dbl  = 0;
        int orig = 0;
        bit src;
        do_reset();
        ready2 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            src = (i < 100) && ($urandom_range(0, 9) < 3);
            a2  = (dbl > 0);
            if (a2) dbl--;
            if (src) begin dbl += 2; orig++; end
            tick();
            vectors++; if (valid2 !== (m_owed[0] > 0)) begin errors++; $display("FAIL rt_valid t=%0t got %b exp %b", $time, valid2, m_owed[0] > 0); end
        end
        vectors++; if (xfer[0] !== orig) begin errors++; $display("FAIL rt_count got %0d exp %0d", xfer[0], orig); end
        vectors++; if (res2 !== 1'b0) begin errors++; $display("FAIL rt_residue got %b exp 0", res2); end
        vectors++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL rt_overflow got %b exp 0", ovf2); end
    endtask

    task automatic test_saturation();
        int x0;
        do_reset();
        a2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            vectors++; if (ovf2 !== (i >= 31)) begin errors++; $display("FAIL sat_overflow token=%0d got %b exp %b", i + 1, ovf2, i >= 31); end
            vectors++; if (valid2 !== (i >= 1)) begin errors++; $display("FAIL sat_valid token=%0d got %b exp %b", i + 1, valid2, i >= 1); end
        end
        a2 = 1'b0;
        ready2 = 1'b1;
        x0 = xfer[0];
        for (int k = 1; k <= 17; k++) begin
            tick();
            vectors++; if (valid2 !== (k < 15)) begin errors++; $display("FAIL drain_valid k=%0d got %b exp %b", k, valid2, k < 15); end
            vectors++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL drain_overflow k=%0d got %b exp 1", k, ovf2); end
        end
        vectors++; if (xfer[0] - x0 !== 15) begin errors++; $display("FAIL drain_count got %0d exp 15", xfer[0] - x0); end
    endtask

    task automatic test_flush();
        do_reset();
        ready4 = 1'b1;
        a4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (res4 !== 2'(i + 1)) begin errors++; $display("FAIL fl_fill got %0d exp %0d", res4, i + 1); end
        end
        a4 = 1'b0; flush4 = 1'b1;
        tick();
        flush4 = 1'b0;
        vectors++; if (res4 !== 2'd0) begin errors++; $display("FAIL fl_clear got %0d exp 0", res4); end
        vectors++; if (valid4 !== 1'b0) begin errors++; $display("FAIL fl_novalid got %b exp 0", valid4); end
        tick();
        vectors++; if (valid4 !== 1'b0) begin errors++; $display("FAIL fl_novalid2 got %b exp 0", valid4); end
        a4 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        flush4 = 1'b1;
        tick();
        flush4 = 1'b0;
        vectors++; if (res4 !== 2'd1) begin errors++; $display("FAIL fl_with_a got %0d exp 1", res4); end
        for (int i = 0; i < 3; i++) tick();
        a4 = 1'b0;
        vectors++; if (res4 !== 2'd0) begin errors++; $display("FAIL fl_regroup got %0d exp 0", res4); end
        for (int i = 0; i < 3; i++) tick();
        vectors++; if (xfer[1] !== 1) begin errors++; $display("FAIL fl_transfers got %0d exp 1", xfer[1]); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        a2 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        ready2 = 1'b1;
        vectors++; if (valid2 !== 1'b1) begin errors++; $display("FAIL sim_pre got %b exp 1", valid2); end
        tick();
        a2 = 1'b0;
        vectors++; if (valid2 !== 1'b1) begin errors++; $display("FAIL sim_hold got %b exp 1", valid2); end
        vectors++; if (res2 !== 1'b0) begin errors++; $display("FAIL sim_residue got %b exp 0", res2); end
        tick();
        vectors++; if (valid2 !== 1'b0) begin errors++; $display("FAIL sim_drain got %b exp 0", valid2); end
        do_reset();
        a2 = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        ready2 = 1'b1;
        tick();
        a2 = 1'b0;
        vectors++; if (ovf2 !== 1'b0) begin errors++; $display("FAIL sim_full_ovf got %b exp 0", ovf2); end
        vectors++; if (valid2 !== 1'b1) begin errors++; $display("FAIL sim_full_valid got %b exp 1", valid2); end
        for (int i = 0; i < 20; i++) tick();
        vectors++; if (xfer[0] !== 16) begin errors++; $display("FAIL sim_full_count got %0d exp 16", xfer[0]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a2 = $urandom_range(0, 1) == 1; flush2 = $urandom_range(0, 7) == 0; ready2 = $urandom_range(0, 2) == 0;
            a4 = $urandom_range(0, 1) == 1; flush4 = $urandom_range(0, 7) == 0; ready4 = $urandom_range(0, 3) == 0;
            tick();
            vectors++; if (valid2 !== (m_owed[0] > 0)) begin errors++; $display("FAIL rnd_valid2 t=%0t got %b exp %b", $time, valid2, m_owed[0] > 0); end
            vectors++; if (res2 !== 1'(m_ph[0])) begin errors++; $display("FAIL rnd_residue2 t=%0t got %0d exp %0d", $time, res2, m_ph[0]); end
            vectors++; if (ovf2 !== m_ovf[0]) begin errors++; $display("FAIL rnd_ovf2 t=%0t got %b exp %b", $time, ovf2, m_ovf[0]); end
            vectors++; if (valid4 !== (m_owed[1] > 0)) begin errors++; $display("FAIL rnd_valid4 t=%0t got %b exp %b", $time, valid4, m_owed[1] > 0); end
            vectors++; if (res4 !== 2'(m_ph[1])) begin errors++; $display("FAIL rnd_residue4 t=%0t got %0d exp %0d", $time, res4, m_ph[1]); end
            vectors++; if (ovf4 !== m_ovf[1]) begin errors++; $display("FAIL rnd_ovf4 t=%0t got %b exp %b", $time, ovf4, m_ovf[1]); end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_ratio2();
        test_round_trip();
        test_saturation();
        test_flush();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
